// File: rtl/picc_tx_encoder.sv
// PICC -> PCD transmit encoder, ISO/IEC 14443-2 Type A (106 kbit/s).
// Manchester coding on an fc/16 subcarrier with on-off keying. A frame is
// a start-of-communication bit, the data bits, then one unmodulated
// end-of-communication bit. Every output is a flop driven from the
// next-state values, so each output matches the state and cnt of its own
// cycle without any combinational glitch.
module picc_tx_encoder #(
  parameter int SC_HALF_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_bit,
  input  logic in_last,
  input  logic in_valid,
  output logic in_ready,
  output logic lm_out,
  output logic idle,
  output logic underrun
);

  localparam int BIT_PERIOD = 16 * SC_HALF_CYCLES;
  localparam int CW         = $clog2(BIT_PERIOD);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(BIT_PERIOD / 2);
  localparam logic [CW-1:0] SC_PERIOD = CW'(2 * SC_HALF_CYCLES);
  localparam logic [CW-1:0] SC_HIGH   = CW'(SC_HALF_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOC  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOC  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_bit_q;
  logic            r_last_q;
  logic            r_lm;
  logic            r_idle;
  logic            r_ready;
  logic            r_underrun;

  state_t          w_state_nx;
  logic [CW-1:0]   w_cnt_nx;
  logic            w_bit_nx;
  logic            w_last_nx;
  logic            w_underrun_nx;
  logic            w_ready_nx;
  logic            w_at_end;

  // Load-modulation level for a given state, bit-cycle count and data bit.
  // Logic 1 and SOC modulate the first half-bit, logic 0 the second half.
  function automatic logic lm_value(input state_t st, input logic [CW-1:0] cnt,
                                    input logic data_bit);
    logic sc;
    logic first;
    sc    = ((cnt % SC_PERIOD) < SC_HIGH);
    first = (cnt < CNT_HALF);
    case (st)
      ST_SOC:  lm_value = first & sc;
      ST_DATA: lm_value = (data_bit ? first : ~first) & sc;
      default: lm_value = 1'b0;
    endcase
  endfunction

  assign w_at_end = (r_cnt == CNT_LAST);

  // Next-state, counter and bit-capture logic for the frame sequencer.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_bit_nx      = r_bit_q;
    w_last_nx     = r_last_q;
    w_underrun_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (in_valid) begin
          w_state_nx = ST_SOC;
          w_bit_nx   = in_bit;
          w_last_nx  = in_last;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SOC: begin
        if (w_at_end) begin
          w_state_nx = ST_DATA;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (w_at_end) begin
          w_cnt_nx = '0;
          if (r_last_q) begin
            w_state_nx = ST_EOC;
          end else if (in_valid) begin
            // Next bit follows with no gap.
            w_bit_nx  = in_bit;
            w_last_nx = in_last;
          end else begin
            // Source ran dry: truncate the frame with a normal EOC.
            w_state_nx    = ST_EOC;
            w_underrun_nx = 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_EOC: begin
        if (w_at_end) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Ready is open in IDLE and on the last cycle of a non-final data bit.
  always_comb begin
    w_ready_nx = (w_state_nx == ST_IDLE) ||
                 ((w_state_nx == ST_DATA) && (w_cnt_nx == CNT_LAST) && !w_last_nx);
  end

  // State registers and registered outputs, derived from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_q    <= 1'b0;
      r_last_q   <= 1'b0;
      r_lm       <= 1'b0;
      r_idle     <= 1'b1;
      r_ready    <= 1'b1;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_bit_q    <= w_bit_nx;
      r_last_q   <= w_last_nx;
      r_lm       <= lm_value(w_state_nx, w_cnt_nx, w_bit_nx);
      r_idle     <= (w_state_nx == ST_IDLE);
      r_ready    <= w_ready_nx;
      r_underrun <= w_underrun_nx;
    end
  end

  assign lm_out   = r_lm;
  assign idle     = r_idle;
  assign in_ready = r_ready;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_picc_tx_encoder.sv
// Self-checking bench for picc_tx_encoder: table-driven frames plus
// hand-written back-to-back, reset-abort and random loopback sequences.
module tb_picc_tx_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_bit = 1'b0;
  logic in_last = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic lm_out;
  logic idle;
  logic underrun;

  int errors = 0;
  int checks = 0;

  // Per-frame results filled by run_frame.
  int res_pre, res_span, res_ready, res_under, res_under_k, res_lm_bad;

  picc_tx_encoder #(.SC_HALF_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_bit   (in_bit),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .lm_out   (lm_out),
    .idle     (idle),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          n;
    int          avail;
    int          exp_span;
    int          exp_ready;
    int          exp_under;
    int          exp_under_k;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference envelope: k cycles after SOC entry, 'sent' data bits.
  function automatic logic exp_lm(input int k, input logic [63:0] d, input int sent);
    int  b;
    int  c;
    logic sc;
    b  = k / 128;
    c  = k % 128;
    sc = ((c % 16) < 8);
    if (b == 0) return (c < 64) ? sc : 1'b0;
    else if (b <= sent) return d[b-1] ? ((c < 64) ? sc : 1'b0) : ((c >= 64) ? sc : 1'b0);
    else return 1'b0;
  endfunction

  // Drive one frame; 'avail' bits are offered (avail < n forces underrun).
  // keep: after the last bit, keep in_valid high with a 1-bit frame of nxt.
  // abort_k >= 0: assert rst_n at that cycle after SOC entry and return.
  task automatic run_frame(input logic [63:0] d, input int n, input int avail,
                           input bit keep, input logic nxt, input int abort_k);
    int  idx;
    int  k;
    int  sent;
    bit  started;
    bit  xfer;
    res_pre = 0; res_span = -1; res_ready = 0; res_under = 0;
    res_under_k = -1; res_lm_bad = 0;
    idx = 0; k = 0; started = 1'b0;
    sent = (avail < n) ? avail : n;
    in_valid = 1'b1; in_bit = d[0]; in_last = (n == 1);
    for (int cyc = 0; cyc < 12000; cyc++) begin
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (started) k++;
      else if (xfer) begin started = 1'b1; k = 0; end
      else res_pre++;
      if (xfer) begin
        idx++;
        if (idx < avail) begin
          in_bit = d[idx]; in_last = (idx == n - 1);
        end else if (keep) begin
          in_bit = nxt; in_last = 1'b1;
        end else begin
          in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        end
      end
      if (started) begin
        if (k == abort_k) begin
          rst_n = 1'b0; #1;
          check("abort_lm_out", int'(lm_out), 0);
          check("abort_idle", int'(idle), 1);
          check("abort_in_ready", int'(in_ready), 1);
          check("abort_underrun", int'(underrun), 0);
          in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
          res_span = -2;
          return;
        end
        if (lm_out !== exp_lm(k, d, sent)) res_lm_bad++;
        if (underrun) begin res_under++; res_under_k = k; end
        if (in_ready && !idle) res_ready++;
        if (idle) begin res_span = k; return; end
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int   nr;
    int   quiet_bad;
    logic [63:0] rd;

    // {data, n, avail, span, ready pulses, underruns, underrun cycle}
    vecs[0] = '{64'h1,  1, 1,  384, 0, 0,  -1};
    vecs[1] = '{64'hA5, 8, 8, 1280, 7, 0,  -1};
    vecs[2] = '{64'h1,  2, 1,  384, 1, 1, 256};
    vecs[3] = '{64'h0,  3, 3,  640, 2, 0,  -1};
    vecs[4] = '{64'hF,  4, 4,  768, 3, 0,  -1};
    vecs[5] = '{64'h3C, 8, 5,  896, 5, 1, 768};

    // Reset state, observed while rst_n is still low.
    repeat (3) @(posedge clk);
    #1;
    check("reset_lm_out", int'(lm_out), 0);
    check("reset_idle", int'(idle), 1);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", int'(in_ready), 1);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].data, vecs[i].n, vecs[i].avail, 1'b0, 1'b0, -1);
      check($sformatf("v%0d_pre", i), res_pre, 0);
      check($sformatf("v%0d_span", i), res_span, vecs[i].exp_span);
      check($sformatf("v%0d_ready", i), res_ready, vecs[i].exp_ready);
      check($sformatf("v%0d_underruns", i), res_under, vecs[i].exp_under);
      check($sformatf("v%0d_underrun_cycle", i), res_under_k, vecs[i].exp_under_k);
      check($sformatf("v%0d_lm_bad", i), res_lm_bad, 0);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back: valid held through EOC, next transfer on first IDLE cycle.
    run_frame(64'h2, 2, 2, 1'b1, 1'b0, -1);
    check("b2b1_span", res_span, 512);
    check("b2b1_lm_bad", res_lm_bad, 0);
    check("b2b1_ready", res_ready, 1);
    check("b2b_idle_now", int'(idle), 1);
    run_frame(64'h0, 1, 1, 1'b0, 1'b0, -1);
    check("b2b2_pre", res_pre, 0);
    check("b2b2_span", res_span, 384);
    check("b2b2_lm_bad", res_lm_bad, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset at cnt = 40 of the third data bit, then a fresh 1-bit frame.
    run_frame(64'h0B, 5, 5, 1'b0, 1'b0, 3 * 128 + 40);
    check("abort_returned", res_span, -2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (lm_out !== 1'b0 || idle !== 1'b1 || underrun !== 1'b0) quiet_bad++;
    end
    check("post_abort_quiet", quiet_bad, 0);
    run_frame(64'h1, 1, 1, 1'b0, 1'b0, -1);
    check("post_abort_span", res_span, 384);
    check("post_abort_lm_bad", res_lm_bad, 0);
    repeat (2) @(posedge clk);
    #1;

    // Random loopback frames against the reference envelope.
    for (int f = 0; f < 6; f++) begin
      nr = $urandom_range(1, 12);
      rd = {$urandom, $urandom};
      run_frame(rd, nr, nr, 1'b0, 1'b0, -1);
      check($sformatf("rnd%0d_span", f), res_span, (nr + 2) * 128);
      check($sformatf("rnd%0d_lm_bad", f), res_lm_bad, 0);
      check($sformatf("rnd%0d_ready", f), res_ready, nr - 1);
      check($sformatf("rnd%0d_underruns", f), res_under, 0);
      repeat (2) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
